// File: rtl/mult_mnbit_1cc.sv
// mult_mnbit_1cc -- unsigned N x M array multiplier with a registered product.
//
// Operands are sampled on a rising clk edge and the full N+M-bit product is
// registered on that same edge (one-cycle latency, one product per cycle).
// The datapath is a gate-level array: AND partial products reduced by M-1
// rows of N-bit ripple adders built from half/full adder cells.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset, clears o
//   g_input  N-bit unsigned multiplicand
//   e_input  M-bit unsigned multiplier
//   o        N+M-bit registered unsigned product

module mult_ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic co
);
  assign s  = a ^ b;
  assign co = a & b;
endmodule

module mult_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module mult_mnbit_1cc #(
  parameter int N = 8,
  parameter int M = N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   g_input,
  input  logic [M-1:0]   e_input,
  output logic [N+M-1:0] o
);

  // Kept as unpacked single-bit arrays so each carry in the ripple chain is
  // its own net rather than a slice of one self-referencing vector.
  logic pp  [M][N];        // pp[j][i] = g[i] & e[j]
  logic a   [1:M-1][N];    // addend into row j: upper bits of the row above
  logic sum [1:M-1][N];    // row j sum bits
  logic cy  [1:M-1][N];    // cy[j][i] = carry out of bit i in row j
  logic [N+M-1:0] prod;

  for (genvar j = 0; j < M; j++) begin : g_pp_row
    for (genvar i = 0; i < N; i++) begin : g_pp_col
      assign pp[j][i] = g_input[i] & e_input[j];
    end
  end

  for (genvar j = 1; j < M; j++) begin : g_row
    for (genvar i = 0; i < N; i++) begin : g_col
      // Shift the previous row down by one: its low bit has already been
      // retired as a product bit, and its carry-out becomes the new MSB.
      // Row 1 takes partial-product row 0 directly (nothing to carry yet).
      if (i < N-1) begin : g_lo
        if (j == 1) begin : g_first
          assign a[j][i] = pp[0][i+1];
        end else begin : g_next
          assign a[j][i] = sum[j-1][i+1];
        end
      end else begin : g_hi
        if (j == 1) begin : g_first
          assign a[j][i] = 1'b0;
        end else begin : g_next
          assign a[j][i] = cy[j-1][N-1];
        end
      end

      if (i == 0) begin : g_ha
        mult_ha u_ha (.a(pp[j][i]), .b(a[j][i]), .s(sum[j][i]), .co(cy[j][i]));
      end else begin : g_fa
        mult_fa u_fa (.a(pp[j][i]), .b(a[j][i]), .ci(cy[j][i-1]),
                      .s(sum[j][i]), .co(cy[j][i]));
      end
    end
  end

  // Low M product bits: bit 0 of each row; top N bits: final row shifted
  // down with its carry-out on top.
  assign prod[0] = pp[0][0];
  for (genvar j = 1; j < M; j++) begin : g_plo
    assign prod[j] = sum[j][0];
  end
  for (genvar i = 0; i < N; i++) begin : g_phi
    if (i < N-1) begin : g_s
      assign prod[M+i] = sum[M-1][i+1];
    end else begin : g_c
      assign prod[M+i] = cy[M-1][N-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) o <= '0;
    else     o <= prod;
  end

endmodule

// File: tb/tb_mult_mnbit_1cc.sv
// tb_mult_mnbit_1cc -- self-checking bench for mult_mnbit_1cc.
// Three instances (8x8, 4x12, 16x16) share clk/rst. Directed vectors run on
// the 8x8 instance; random vectors drive all three against an integer model.

module tb_mult_mnbit_1cc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  g8  = '0, e8  = '0;
  logic [3:0]  g4  = '0;
  logic [11:0] e12 = '0;
  logic [15:0] g16 = '0, e16 = '0;
  logic [15:0] o8, o4;
  logic [31:0] o16;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mult_mnbit_1cc #(.N(8),  .M(8))  d8  (.clk(clk), .rst(rst), .g_input(g8),  .e_input(e8),  .o(o8));
  mult_mnbit_1cc #(.N(4),  .M(12)) d4  (.clk(clk), .rst(rst), .g_input(g4),  .e_input(e12), .o(o4));
  mult_mnbit_1cc #(.N(16), .M(16)) d16 (.clk(clk), .rst(rst), .g_input(g16), .e_input(e16), .o(o16));

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Active edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed 8x8 vectors: {g, e, product}
  localparam int ND = 11;
  logic [7:0]  dg [ND] = '{8'hFF, 8'hFF, 8'h7F, 8'h42, 8'h47, 8'h23, 8'h64, 8'h32, 8'h00, 8'h01, 8'h80};
  logic [7:0]  de [ND] = '{8'hFF, 8'h47, 8'h47, 8'h47, 8'h47, 8'h47, 8'h47, 8'h13, 8'hFF, 8'hA5, 8'h02};
  logic [15:0] dp [ND] = '{16'hFE01, 16'h46B9, 16'h2339, 16'h124E, 16'h13B1, 16'h09B5,
                           16'h1BBC, 16'h03B6, 16'h0000, 16'h00A5, 16'h0100};

  logic [63:0] x8, x4, x16;

  initial begin
    // Reset holds o at zero even with max operands present.
    rst = 1'b1; g8 = 8'hFF; e8 = 8'hFF;
    g4 = 4'hF; e12 = 12'hFFF; g16 = 16'hFFFF; e16 = 16'hFFFF;
    tick();
    chk("rst_o8",  64'(o8),  64'h0);
    chk("rst_o4",  64'(o4),  64'h0);
    chk("rst_o16", 64'(o16), 64'h0);

    // First edge with rst low registers the current operands.
    rst = 1'b0;
    tick();
    chk("post_rst_o8",  64'(o8),  64'hFE01);
    chk("post_rst_o4",  64'(o4),  64'(16'hF * 16'hFFF));
    chk("post_rst_o16", 64'(o16), 64'hFFFE0001);

    // Back-to-back directed operands, new pair every cycle.
    for (int k = 0; k < ND; k++) begin
      g8 = dg[k]; e8 = de[k];
      tick();
      chk($sformatf("dir%0d_%h_x_%h", k, dg[k], de[k]), 64'(o8), 64'(dp[k]));
    end

    // Commutativity of the 8x8 instance.
    g8 = 8'h47; e8 = 8'h7F;
    tick();
    chk("commute_47x7F", 64'(o8), 64'h2339);

    // Asserting rst between edges leaves o alone until the next edge.
    g8 = 8'h64; e8 = 8'h47;
    rst = 1'b1;
    #3;
    chk("rst_async_hold", 64'(o8), 64'h2339);
    tick();
    chk("mid_rst", 64'(o8), 64'h0);
    rst = 1'b0;
    tick();
    chk("mid_rst_resume", 64'(o8), 64'h1BBC);

    // Random regression on all three instances.
    for (int k = 0; k < 10000; k++) begin
      g8  = 8'($urandom);  e8  = 8'($urandom);
      g4  = 4'($urandom);  e12 = 12'($urandom);
      g16 = 16'($urandom); e16 = 16'($urandom);
      if (k % 97 == 0) begin g8 = 8'hFF; e16 = 16'h0; end
      x8  = 64'(g8)  * 64'(e8);
      x4  = 64'(g4)  * 64'(e12);
      x16 = 64'(g16) * 64'(e16);
      tick();
      chk("rnd8x8",   64'(o8),  x8);
      chk("rnd4x12",  64'(o4),  x4);
      chk("rnd16x16", 64'(o16), x16);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
